// File: rtl/key_scan_4x4.sv
// 4x4 keypad scanner: walks an active-low row strobe on each 1 kHz tick and
// debounces whole-keypad frames into a single accepted key code per press.
`timescale 1ns/1ps
module key_scan_4x4 #(
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1khz,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  // state    | meaning
  // IDLE     | no key accepted, waiting for a single-key frame
  // DEBOUNCE | counting identical single-key frames for cand
  // PRESSED  | key accepted and still held
  // RELEASE  | counting empty frames before returning to IDLE
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  state_t      state, state_nxt;
  logic        clk_1khz_d;
  logic [3:0]  col_meta, col_sync;
  logic [1:0]  row_idx;
  logic [11:0] hits;
  logic [3:0]  cand, cand_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  code_nxt;
  logic        valid_nxt, held_nxt;
  logic        tick, frame_done, single;
  logic [15:0] frame_keys;
  logic [4:0]  n_hit;
  logic [3:0]  hit_code;

  assign tick       = clk_1khz & ~clk_1khz_d;
  assign frame_done = tick && (row_idx == 2'd3);
  assign frame_keys = {~col_sync, hits};
  assign row        = ~(4'b0001 << row_idx);

  always_comb begin
    n_hit    = '0;
    hit_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_keys[i]) begin
        n_hit    = n_hit + 5'd1;
        hit_code = 4'(i);
      end
    end
  end

  assign single = (n_hit == 5'd1);

  // Each tick samples the row driven for the past 1 ms, then moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_1khz_d <= 1'b1;
      col_meta   <= 4'b1111;
      col_sync   <= 4'b1111;
      row_idx    <= 2'd0;
      hits       <= '0;
    end else begin
      clk_1khz_d <= clk_1khz;
      col_meta   <= col;
      col_sync   <= col_meta;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        case (row_idx)
          2'd0:    hits[3:0]  <= ~col_sync;
          2'd1:    hits[7:4]  <= ~col_sync;
          2'd2:    hits[11:8] <= ~col_sync;
          default: hits       <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (single) begin
            cand_nxt = hit_code;
            if (DF == 4'd1) begin
              code_nxt  = hit_code;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = PRESSED;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!single) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (hit_code != cand) begin
            cand_nxt = hit_code;
            cnt_nxt  = 4'd1;
          end else if (cnt + 4'd1 == DF) begin
            code_nxt  = cand;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = PRESSED;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        PRESSED: begin
          // A different single key while held is ignored until full release.
          if (!single) begin
            if (DF == 4'd1) begin
              held_nxt  = 1'b0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt   = 4'd1;
              state_nxt = RELEASE;
            end
          end
        end
        default: begin
          if (single) begin
            cnt_nxt   = '0;
            state_nxt = PRESSED;
          end else if (cnt + 4'd1 == DF) begin
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_scan_4x4.sv
// Directed bench for key_scan_4x4: models a keypad matrix and a fast scan
// strobe (16 clk period) so each frame is 64 clk.
`timescale 1ns/1ps
module tb_key_scan_4x4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_1khz;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = '0;
  logic        run_1k = 1'b0;
  int          pulse_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          p0;

  key_scan_4x4 #(.DEBOUNCE_FRAMES(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_1khz  (clk_1khz),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #10 clk = ~clk;

  initial begin
    int div;
    div = 0;
    clk_1khz = 1'b0;
    forever begin
      @(negedge clk);
      if (!run_1k) begin
        clk_1khz = 1'b0;
        div = 0;
      end else begin
        div++;
        if (div == 8) begin
          div = 0;
          clk_1khz = ~clk_1khz;
        end
      end
    end
  end

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = ~keys[r*4 +: 4];
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && key_valid === 1'b1) pulse_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * 4) @(posedge clk_1khz);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_row [4];
    exp_row[0] = 4'b1101; exp_row[1] = 4'b1011;
    exp_row[2] = 4'b0111; exp_row[3] = 4'b1110;

    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_row", row, 4'b1110);
    check("reset_code", key_code, 0);
    check("reset_valid", key_valid, 0);
    check("reset_held", key_held, 0);
    rst_n = 1'b1;
    run_1k = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_1khz);
      repeat (3) @(negedge clk);
      check($sformatf("row_step%0d", i), row, exp_row[i]);
    end
    repeat (1) @(negedge clk);

    // Clean press of key 10
    p0 = pulse_cnt;
    keys = 16'h0400;
    frames(4);
    check("clean_no_early", pulse_cnt - p0, 0);
    frames(1);
    check("clean_pulse", pulse_cnt - p0, 1);
    check("clean_code", key_code, 10);
    check("clean_held", key_held, 1);
    frames(3);
    check("clean_single", pulse_cnt - p0, 1);
    keys = '0;
    frames(4);
    check("clean_rel4_held", key_held, 1);
    frames(1);
    check("clean_rel5_held", key_held, 0);

    // Bouncing key 5, then stable
    p0 = pulse_cnt;
    for (int b = 0; b < 2; b++) begin
      keys = 16'h0020;
      frames(2);
      keys = '0;
      frames(2);
    end
    check("bounce_none", pulse_cnt - p0, 0);
    keys = 16'h0020;
    frames(4);
    check("bounce_no_early", pulse_cnt - p0, 0);
    frames(1);
    check("bounce_pulse", pulse_cnt - p0, 1);
    check("bounce_code", key_code, 5);
    frames(1);

    // Short release then re-press, then full release and re-press
    keys = '0;
    frames(3);
    check("short_rel_held", key_held, 1);
    keys = 16'h0020;
    frames(2);
    check("repress_no_pulse", pulse_cnt - p0, 1);
    check("repress_held", key_held, 1);
    keys = '0;
    frames(5);
    check("full_rel_held", key_held, 0);
    keys = 16'h0020;
    frames(5);
    check("second_pulse", pulse_cnt - p0, 2);
    check("second_code", key_code, 5);
    keys = '0;
    frames(5);
    check("code_kept", key_code, 5);
    check("idle_held", key_held, 0);

    // Two keys together are rejected; key 0 alone is accepted
    p0 = pulse_cnt;
    keys = 16'h8001;
    frames(10);
    check("multi_none", pulse_cnt - p0, 0);
    check("multi_held", key_held, 0);
    keys = 16'h0001;
    frames(4);
    check("multi_no_early", pulse_cnt - p0, 0);
    frames(1);
    check("multi_pulse", pulse_cnt - p0, 1);
    check("multi_code", key_code, 0);
    keys = '0;
    frames(5);

    // Reset in the middle of debouncing key 3
    keys = 16'h0008;
    frames(3);
    rst_n = 1'b0;
    run_1k = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_row", row, 4'b1110);
    check("midrst_code", key_code, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    run_1k = 1'b1;
    frames(4);
    check("midrst_no_early", pulse_cnt - p0, 0);
    frames(1);
    check("midrst_pulse", pulse_cnt - p0, 1);
    check("midrst_code3", key_code, 3);

    // Stopped strobe freezes scanning and outputs
    p0 = pulse_cnt;
    run_1k = 1'b0;
    keys = '0;
    repeat (200) @(negedge clk);
    check("freeze_row", row, 4'b1110);
    check("freeze_held", key_held, 1);
    check("freeze_pulse", pulse_cnt - p0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
